// File: rtl/div_ctrl.sv
// Iterative radix-2 divider sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional result cache enabled by defining DIV_RES_CACHE_EN.
module div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_flush,
  input  logic            ex_valid,
  input  logic            ex_is_div_inst,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  input  logic            mem_allowin,
  output logic            ex_div_done,
  output logic [XLEN-1:0] div_res,
  output logic            div_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] a);
    return ~a + XLEN'(1);
  endfunction

  state_t            state_r, state_nxt_s;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   src1_r, src2_r, dvs_r, rem_r, quo_r, res_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              q_neg_r, r_neg_r, done_r;

  logic              start_s, signed_s, s1_s, s2_s, div_zero_s, ovf_s, last_s, ge_s;
  logic              enter_done_s, hit_s;
  logic [XLEN-1:0]   abs1_s, abs2_s, rem_it_s, quo_it_s, q_fin_s, r_fin_s, res_sel_s, hit_res_s;
  logic [XLEN:0]     rem_sh_s, diff_s;

  assign start_s    = ex_valid & ex_is_div_inst & ~pipe_flush;
  assign signed_s   = ~op_r[0];
  assign s1_s       = signed_s & src1_r[XLEN-1];
  assign s2_s       = signed_s & src2_r[XLEN-1];
  assign abs1_s     = s1_s ? negate(src1_r) : src1_r;
  assign abs2_s     = s2_s ? negate(src2_r) : src2_r;
  assign div_zero_s = (src2_r == {XLEN{1'b0}});
  assign ovf_s      = signed_s & (src1_r == {1'b1, {(XLEN-1){1'b0}}}) & (src2_r == {XLEN{1'b1}});
  assign last_s     = (cnt_r == CNT_W'(XLEN-1));

  // one shift-subtract step on the current partial remainder/quotient
  assign rem_sh_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_r};
  assign ge_s     = (rem_sh_s >= {1'b0, dvs_r});
  assign rem_it_s = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_it_s = {quo_r[XLEN-2:0], ge_s};

  assign enter_done_s = (state_nxt_s == DONE) && (state_r != DONE);

  // final signed quotient/remainder, including the special-case shortcuts from PREP
  always_comb begin
    q_fin_s = {XLEN{1'b0}};
    r_fin_s = {XLEN{1'b0}};
    if ((state_r == PREP) && div_zero_s) begin
      q_fin_s = {XLEN{1'b1}};
      r_fin_s = src1_r;
    end else if ((state_r == PREP) && ovf_s) begin
      q_fin_s = {1'b1, {(XLEN-1){1'b0}}};
      r_fin_s = {XLEN{1'b0}};
    end else begin
      q_fin_s = q_neg_r ? negate(quo_it_s) : quo_it_s;
      r_fin_s = r_neg_r ? negate(rem_it_s) : rem_it_s;
    end
  end

  // result to capture on DONE entry; from IDLE only a cache hit can enter DONE
  always_comb begin
    res_sel_s = {XLEN{1'b0}};
    if (state_r == IDLE) begin
      res_sel_s = hit_res_s;
    end else begin
      res_sel_s = op_r[1] ? r_fin_s : q_fin_s;
    end
  end

`ifdef DIV_RES_CACHE_EN
  logic            c_vld_r, c_sgn_r;
  logic [XLEN-1:0] c_src1_r, c_src2_r, c_q_r, c_r_r;

  assign hit_s     = c_vld_r & (c_src1_r == div_src1) & (c_src2_r == div_src2) & (c_sgn_r == ~div_op[0]);
  assign hit_res_s = div_op[1] ? c_r_r : c_q_r;

  // last completed operation; aborted computations invalidate it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld_r  <= 1'b0;
      c_sgn_r  <= 1'b0;
      c_src1_r <= {XLEN{1'b0}};
      c_src2_r <= {XLEN{1'b0}};
      c_q_r    <= {XLEN{1'b0}};
      c_r_r    <= {XLEN{1'b0}};
    end else if (pipe_flush && ((state_r == PREP) || (state_r == CALC))) begin
      c_vld_r <= 1'b0;
    end else if (enter_done_s && (state_r != IDLE)) begin
      c_vld_r  <= 1'b1;
      c_sgn_r  <= signed_s;
      c_src1_r <= src1_r;
      c_src2_r <= src2_r;
      c_q_r    <= q_fin_s;
      c_r_r    <= r_fin_s;
    end
  end
`else
  assign hit_s     = 1'b0;
  assign hit_res_s = {XLEN{1'b0}};
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && hit_s) begin
          state_nxt_s = DONE;
        end else if (start_s) begin
          state_nxt_s = PREP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PREP:    state_nxt_s = (div_zero_s || ovf_s) ? DONE : CALC;
      CALC:    state_nxt_s = last_s ? DONE : CALC;
      DONE:    state_nxt_s = mem_allowin ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
    if (pipe_flush) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 2'b00;
      src1_r  <= {XLEN{1'b0}};
      src2_r  <= {XLEN{1'b0}};
      dvs_r   <= {XLEN{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      quo_r   <= {XLEN{1'b0}};
      res_r   <= {XLEN{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == DONE);
      if (enter_done_s) begin
        res_r <= res_sel_s;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            op_r   <= div_op;
            src1_r <= div_src1;
            src2_r <= div_src2;
          end
        end
        PREP: begin
          cnt_r   <= {CNT_W{1'b0}};
          q_neg_r <= s1_s ^ s2_s;
          r_neg_r <= s1_s;
          dvs_r   <= abs2_s;
          quo_r   <= abs1_s;
          rem_r   <= {XLEN{1'b0}};
        end
        CALC: begin
          rem_r <= rem_it_s;
          quo_r <= quo_it_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign ex_div_done = done_r;
  assign div_res     = res_r;
  assign div_busy    = (state_r != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: results, latency, hold/release, flush and special cases.
module tb_div_ctrl;

`ifdef DIV_RES_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, pipe_flush, ex_valid, ex_is_div_inst, mem_allowin;
  logic [1:0]  div_op;
  logic [31:0] div_src1, div_src2, div_res;
  logic        ex_div_done, div_busy;
  int          checks = 0;
  int          errors = 0;

  div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .ex_valid(ex_valid),
    .ex_is_div_inst(ex_is_div_inst), .div_op(div_op), .div_src1(div_src1),
    .div_src2(div_src2), .mem_allowin(mem_allowin), .ex_div_done(ex_div_done),
    .div_res(div_res), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op, measure latency (cycle 1 = just after the start-sample edge), check hold and release.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    ex_valid = 1'b1; ex_is_div_inst = 1'b1; div_op = op;
    div_src1 = a; div_src2 = b; mem_allowin = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(div_busy), 32'd1);
    lat = 1;
    while (!ex_div_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, div_res, exp_res);
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_hold_done"}, 32'(ex_div_done), 32'd1);
    chk({tag, "_hold_res"}, div_res, exp_res);
    mem_allowin = 1'b1;
    @(posedge clk); #1;
    mem_allowin = 1'b0; ex_valid = 1'b0;
    chk({tag, "_rel_done"}, 32'(ex_div_done), 32'd0);
    chk({tag, "_rel_busy"}, 32'(div_busy), 32'd0);
    chk({tag, "_rel_res"}, div_res, exp_res);
  endtask

  initial begin
    int n;
    logic done_seen;
    rst_n = 1'b0; pipe_flush = 1'b0; ex_valid = 1'b0; ex_is_div_inst = 1'b0;
    mem_allowin = 1'b0; div_op = 2'b00; div_src1 = 32'd0; div_src2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(ex_div_done), 32'd0);
    chk("rst_res", div_res, 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, CACHE ? 1 : 34);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 2);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, CACHE ? 1 : 2);

    // flush asserted in IDLE together with a valid divide: no start
    ex_valid = 1'b1; ex_is_div_inst = 1'b1; div_op = 2'b01; div_src1 = 32'd50; div_src2 = 32'd5;
    pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0; ex_valid = 1'b0;
    chk("flush_idle_busy", 32'(div_busy), 32'd0);

    // flush in the 10th CALC cycle
    ex_valid = 1'b1; div_op = 2'b01; div_src1 = 32'd1000; div_src2 = 32'd3;
    done_seen = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      done_seen = done_seen | ex_div_done;
      @(posedge clk); #1;
    end
    chk("flush_calc_busy_pre", 32'(div_busy), 32'd1);
    pipe_flush = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    chk("flush_calc_busy", 32'(div_busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      done_seen = done_seen | ex_div_done;
      @(posedge clk); #1;
    end
    chk("flush_calc_no_done", 32'(done_seen), 32'd0);

    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34);

    // flush and mem_allowin together in DONE: flush wins
    ex_valid = 1'b1; div_op = 2'b01; div_src1 = 32'd20; div_src2 = 32'd4;
    @(posedge clk); #1;
    n = 1;
    while (!ex_div_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fd_res", div_res, 32'd5);
    pipe_flush = 1'b1; mem_allowin = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    pipe_flush = 1'b0; mem_allowin = 1'b0;
    chk("fd_done", 32'(ex_div_done), 32'd0);
    chk("fd_busy", 32'(div_busy), 32'd0);

    run_op("divu_100_7b", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, CACHE ? 1 : 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
